// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV32I load/store funct3 codes, LSU state encoding,
// reset address default and the access legality check used by the memory stage.
package pipe_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] LSU_IDLE    = 2'd0;
  localparam logic [1:0] LSU_RD_WAIT = 2'd1;
  localparam logic [1:0] LSU_WR_WAIT = 2'd2;

  localparam logic [31:0] LSU_RESET_ADDR = 32'h0000_0000;

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (is_store) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else          legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    case (f3[1:0])
      2'b01:   aligned = !addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated store data, and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    byte_en_o    = 4'b1111;
    store_data_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        byte_en_o    = 4'b0001 << addr_lo_i;
        store_data_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        store_data_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword loads are aligned, so a byte-granular shift also selects the halfword.
  assign shifted = load_word_i >> {addr_lo_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one load/store to the data-memory ready/valid bus
// and returns load results to write-back. Optional watchdog: LSU_TIMEOUT_EN.
module load_store_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR     = LSU_RESET_ADDR,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_address,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest_reg_sel,
  output logic        lsu_stall,
  output logic        dmem_read_ready,
  output logic [31:0] dmem_read_address,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_read_valid,
  output logic        dmem_write_ready,
  output logic [31:0] dmem_write_address,
  output logic [31:0] dmem_write_data,
  output logic [3:0]  dmem_write_byte,
  input  logic        dmem_write_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_dest_reg_sel,
  output logic [31:0] wb_read_data,
  output logic        access_fault,
  output logic [31:0] fault_address
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [4:0]  dest_q, dest_d;
  logic        flushed_q, flushed_d;
  logic        rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic [31:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_byte_q, wr_byte_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        is_store, accept, access_legal, accept_legal, accept_bad;
  logic        rd_resp, wr_resp, timeout;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic [3:0]  al_byte;
  logic [31:0] al_store, al_load;

  // A request with both read and write set is treated as a store.
  assign is_store     = ex_mem_write;
  assign accept       = (state_q == LSU_IDLE) && ex_valid && !stall && (ex_mem_read || ex_mem_write);
  assign access_legal = access_ok(is_store, ex_funct3, ex_address[1:0]);
  assign accept_legal = accept && access_legal;
  assign accept_bad   = accept && !access_legal;
  assign rd_resp      = (state_q == LSU_RD_WAIT) && dmem_read_valid;
  assign wr_resp      = (state_q == LSU_WR_WAIT) && dmem_write_valid;

  // The aligner serves the new store at accept and the pending load at response.
  assign align_f3 = (state_q == LSU_RD_WAIT) ? f3_q : ex_funct3;
  assign align_lo = (state_q == LSU_RD_WAIT) ? lo_q : ex_address[1:0];

  lsu_align u_align (
    .funct3_i     (align_f3),
    .addr_lo_i    (align_lo),
    .store_data_i (ex_store_data),
    .load_word_i  (dmem_read_data),
    .byte_en_o    (al_byte),
    .store_data_o (al_store),
    .load_data_o  (al_load)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d   = (state_q == LSU_IDLE) ? '0 : cnt_q + 1'b1;
  assign timeout = (state_q != LSU_IDLE) && !rd_resp && !wr_resp &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign lsu_stall = accept_legal || ((state_q != LSU_IDLE) && !rd_resp && !wr_resp && !timeout);

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
    dest_d       = dest_q;
    flushed_d    = flushed_q;
    rd_ready_d   = rd_ready_q;
    wr_ready_d   = wr_ready_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_byte_d    = wr_byte_q;
    wb_valid_d   = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept_legal) begin
          f3_d      = ex_funct3;
          lo_d      = ex_address[1:0];
          dest_d    = ex_dest_reg_sel;
          flushed_d = 1'b0;
          if (is_store) begin
            state_d    = LSU_WR_WAIT;
            wr_ready_d = 1'b1;
            wr_addr_d  = {ex_address[31:2], 2'b00};
            wr_data_d  = al_store;
            wr_byte_d  = al_byte;
          end else begin
            state_d    = LSU_RD_WAIT;
            rd_ready_d = 1'b1;
            rd_addr_d  = {ex_address[31:2], 2'b00};
          end
        end else if (accept_bad) begin
          fault_d      = 1'b1;
          fault_addr_d = ex_address;
        end
      end
      LSU_RD_WAIT: begin
        if (flush) flushed_d = 1'b1;
        if (rd_resp) begin
          state_d    = LSU_IDLE;
          rd_ready_d = 1'b0;
          if (!(flushed_q || flush)) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_q;
            wb_data_d  = al_load;
          end
        end else if (timeout) begin
          state_d      = LSU_IDLE;
          rd_ready_d   = 1'b0;
          fault_d      = 1'b1;
          fault_addr_d = {rd_addr_q[31:2], lo_q};
        end
      end
      LSU_WR_WAIT: begin
        if (wr_resp) begin
          state_d    = LSU_IDLE;
          wr_ready_d = 1'b0;
        end else if (timeout) begin
          state_d      = LSU_IDLE;
          wr_ready_d   = 1'b0;
          fault_d      = 1'b1;
          fault_addr_d = {wr_addr_q[31:2], lo_q};
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LSU_IDLE;
      f3_q         <= '0;
      lo_q         <= '0;
      dest_q       <= '0;
      flushed_q    <= 1'b0;
      rd_ready_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
      rd_addr_q    <= RESET_ADDR;
      wr_addr_q    <= RESET_ADDR;
      wr_data_q    <= '0;
      wr_byte_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
      dest_q       <= dest_d;
      flushed_q    <= flushed_d;
      rd_ready_q   <= rd_ready_d;
      wr_ready_q   <= wr_ready_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_byte_q    <= wr_byte_d;
      wb_valid_q   <= wb_valid_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dmem_read_ready    = rd_ready_q;
  assign dmem_read_address  = rd_addr_q;
  assign dmem_write_ready   = wr_ready_q;
  assign dmem_write_address = wr_addr_q;
  assign dmem_write_data    = wr_data_q;
  assign dmem_write_byte    = wr_byte_q;
  assign wb_valid           = wb_valid_q;
  assign wb_dest_reg_sel    = wb_dest_q;
  assign wb_read_data       = wb_data_q;
  assign access_fault       = fault_q;
  assign fault_address      = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected write-back,
// store-bus and fault records; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_address = '0, ex_store_data = '0;
  logic [4:0]  ex_dest_reg_sel = '0;
  logic        lsu_stall;
  logic        dmem_read_ready, dmem_write_ready;
  logic [31:0] dmem_read_address, dmem_write_address, dmem_write_data;
  logic [31:0] dmem_read_data = '0;
  logic        dmem_read_valid = 1'b0, dmem_write_valid = 1'b0;
  logic [3:0]  dmem_write_byte;
  logic        wb_valid, access_fault;
  logic [4:0]  wb_dest_reg_sel;
  logic [31:0] wb_read_data, fault_address;

  int checks = 0;
  int errors = 0;

  logic [36:0] wb_exp_q[$];     // {dest, data}
  logic [67:0] wr_exp_q[$];     // {addr, byte, data}
  logic [31:0] fault_exp_q[$];
  logic        wr_ready_prev = 1'b0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_address(ex_address), .ex_store_data(ex_store_data),
    .ex_dest_reg_sel(ex_dest_reg_sel), .lsu_stall(lsu_stall),
    .dmem_read_ready(dmem_read_ready), .dmem_read_address(dmem_read_address),
    .dmem_read_data(dmem_read_data), .dmem_read_valid(dmem_read_valid),
    .dmem_write_ready(dmem_write_ready), .dmem_write_address(dmem_write_address),
    .dmem_write_data(dmem_write_data), .dmem_write_byte(dmem_write_byte),
    .dmem_write_valid(dmem_write_valid), .wb_valid(wb_valid),
    .wb_dest_reg_sel(wb_dest_reg_sel), .wb_read_data(wb_read_data),
    .access_fault(access_fault), .fault_address(fault_address)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_exp_q.size() == 0) check("wb_unexpected", 68'(wb_read_data), 68'hX);
      else check("wb_result", 68'({wb_dest_reg_sel, wb_read_data}), 68'(wb_exp_q.pop_front()));
    end
    if (access_fault) begin
      if (fault_exp_q.size() == 0) check("fault_unexpected", 68'(fault_address), 68'hX);
      else check("fault_addr", 68'(fault_address), 68'(fault_exp_q.pop_front()));
    end
    if (dmem_write_ready && !wr_ready_prev) begin
      if (wr_exp_q.size() == 0) check("write_unexpected", 68'(dmem_write_address), 68'hX);
      else check("write_req", {dmem_write_address, dmem_write_byte, dmem_write_data}, wr_exp_q.pop_front());
    end
    wr_ready_prev <= dmem_write_ready;
  end

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dest);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_address = addr; ex_store_data = data; ex_dest_reg_sel = dest;
  endtask

  task automatic clear_op();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [4:0] dest, input int wait_cycles, input logic fl);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    set_op(1'b1, 1'b0, f3, addr, 32'h0, dest);
    @(posedge clk); #1; clear_op();
    repeat (wait_cycles) begin flush = fl; @(posedge clk); #1; end
    flush = 1'b0; dmem_read_data = rdata; dmem_read_valid = 1'b1;
    @(negedge clk);
    check("rd_req", {dmem_read_ready, dmem_read_address}, {1'b1, word_addr});
    @(posedge clk); #1; dmem_read_valid = 1'b0;
    @(negedge clk);
    check("wb_timing", 68'(wb_valid), 68'(!fl));
    @(posedge clk); #1;
  endtask

  task automatic store_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input int wait_cycles, output int stalls);
    stalls = 0;
    set_op(1'b0, 1'b1, f3, addr, data, 5'd0);
    @(negedge clk); stalls += int'(lsu_stall);
    @(posedge clk); #1; clear_op();
    repeat (wait_cycles) begin @(negedge clk); stalls += int'(lsu_stall); @(posedge clk); #1; end
    dmem_write_valid = 1'b1;
    @(negedge clk); stalls += int'(lsu_stall);
    check("wr_ready_held", 68'(dmem_write_ready), 68'd1);
    @(posedge clk); #1; dmem_write_valid = 1'b0;
    @(negedge clk);
    check("wr_ready_drop", 68'({dmem_write_ready, lsu_stall}), 68'd0);
    @(posedge clk); #1;
  endtask

  task automatic fault_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    fault_exp_q.push_back(addr);
    set_op(rd, wr, f3, addr, 32'h0, 5'd1);
    @(negedge clk); check("fault_no_stall", 68'(lsu_stall), 68'd0);
    @(posedge clk); #1; clear_op();
    @(negedge clk);
    check("fault_pulse", 68'({access_fault, dmem_read_ready, dmem_write_ready}), 68'b100);
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    #23;
    check("reset_outs", 68'({lsu_stall, dmem_read_ready, dmem_write_ready, wb_valid, access_fault}), 68'd0);
    check("reset_addrs", 68'({dmem_read_address, dmem_write_address}), 68'd0);
    check("reset_data", 68'({dmem_write_data, dmem_write_byte, wb_read_data}), 68'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    // Stores: lane enables and replicated data
    wr_exp_q.push_back({32'h100, 4'b1000, 32'hA5A5A5A5});
    store_op(3'b000, 32'h103, 32'h0000_00A5, 2, st);
    check("sb_stall_cycles", 68'(st), 68'd3);
    wr_exp_q.push_back({32'h200, 4'b1100, 32'h12341234});
    store_op(3'b001, 32'h202, 32'h0000_1234, 0, st);
    wr_exp_q.push_back({32'h300, 4'b1111, 32'hCAFEF00D});
    store_op(3'b010, 32'h300, 32'hCAFEF00D, 1, st);
    // Both read and write set: the store wins
    wr_exp_q.push_back({32'h040, 4'b0011, 32'hBEEFBEEF});
    set_op(1'b1, 1'b1, 3'b001, 32'h040, 32'h0000_BEEF, 5'd0);
    @(posedge clk); #1; clear_op(); dmem_write_valid = 1'b1;
    @(negedge clk); check("rw_is_store", 68'({dmem_write_ready, dmem_read_ready}), 68'b10);
    @(posedge clk); #1; dmem_write_valid = 1'b0;

    // Loads: extraction and extension
    wb_exp_q.push_back({5'd5, 32'hFFFFFF80});
    load_op(3'b000, 32'h102, 32'h0080FF00, 5'd5, 0, 1'b0);
    wb_exp_q.push_back({5'd6, 32'h00000080});
    load_op(3'b100, 32'h102, 32'h0080FF00, 5'd6, 0, 1'b0);
    wb_exp_q.push_back({5'd7, 32'hFFFFFF00});
    load_op(3'b001, 32'h100, 32'h0080FF00, 5'd7, 1, 1'b0);
    wb_exp_q.push_back({5'd8, 32'h00000080});
    load_op(3'b101, 32'h102, 32'h0080FF00, 5'd8, 0, 1'b0);
    wb_exp_q.push_back({5'd9, 32'hFFFFFFFF});
    load_op(3'b000, 32'h101, 32'h0080FF00, 5'd9, 0, 1'b0);
    wb_exp_q.push_back({5'd31, 32'hDEADBEEF});
    load_op(3'b010, 32'h104, 32'hDEADBEEF, 5'd31, 3, 1'b0);

    // Misaligned and illegal accesses
    fault_op(1'b1, 1'b0, 3'b010, 32'h1002);
    fault_op(1'b1, 1'b0, 3'b001, 32'h203);
    fault_op(1'b1, 1'b0, 3'b011, 32'h000);
    fault_op(1'b0, 1'b1, 3'b100, 32'h010);
    fault_op(1'b0, 1'b1, 3'b001, 32'h201);

    // Flush in RD_WAIT suppresses write-back; next op still accepted
    load_op(3'b001, 32'h200, 32'h12345678, 5'd3, 1, 1'b1);
    wb_exp_q.push_back({5'd4, 32'h00000056});
    load_op(3'b100, 32'h201, 32'h12345678, 5'd4, 0, 1'b0);

    // Global stall blocks acceptance; stray response in IDLE is ignored
    stall = 1'b1;
    set_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd2);
    @(negedge clk); check("stall_no_accept", 68'(lsu_stall), 68'd0);
    @(posedge clk); #1; clear_op(); stall = 1'b0;
    dmem_read_valid = 1'b1; dmem_write_valid = 1'b1;
    @(negedge clk); check("stall_idle", 68'({dmem_read_ready, lsu_stall}), 68'd0);
    @(posedge clk); #1; dmem_read_valid = 1'b0; dmem_write_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in WR_WAIT
    wr_exp_q.push_back({32'h340, 4'b1111, 32'h11223344});
    set_op(1'b0, 1'b1, 3'b010, 32'h340, 32'h11223344, 5'd0);
    @(posedge clk); #1; clear_op();
    @(negedge clk); #2; reset = 1'b1; #1;
    check("async_reset", {dmem_write_ready, dmem_read_address, dmem_write_address, lsu_stall}, 68'd0);
    @(posedge clk); #1; reset = 1'b0; dmem_write_valid = 1'b1;
    @(negedge clk); check("stray_wvalid", 68'({dmem_write_ready, lsu_stall, access_fault}), 68'd0);
    @(posedge clk); #1; dmem_write_valid = 1'b0;
    wb_exp_q.push_back({5'd10, 32'h00000012});
    load_op(3'b100, 32'h343, 32'h12000000, 5'd10, 0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int ready_cycles;
      ready_cycles = 0;
      fault_exp_q.push_back(32'h400);
      set_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd1);
      @(posedge clk); #1; clear_op();
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (access_fault) break;
        ready_cycles += int'(dmem_read_ready);
      end
      check("timeout_cycles", 68'(ready_cycles), 68'd255);
      check("timeout_drop", 68'({access_fault, dmem_read_ready}), 68'b10);
      @(posedge clk); #1;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("wb_queue_empty", 68'(wb_exp_q.size()), 68'd0);
    check("wr_queue_empty", 68'(wr_exp_q.size()), 68'd0);
    check("fault_queue_empty", 68'(fault_exp_q.size()), 68'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between `execute` and `wb` in the three-stage RV32I pipe.
- Takes one load/store per request from execute and drives the data-memory ready/valid interface.
- Generates byte enables, aligns store data and sign/zero-extends load data.
- Hands completed loads to write-back and stalls the pipe while a bus access is outstanding.

Parameters:
- RESET_ADDR, 32'h0000_0000, value driven on address outputs after reset.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  global stall; blocks acceptance of new requests.
- flush  in  1  squashes write-back of the in-flight load.
- ex_valid  in  1  execute presents a memory op.
- ex_mem_read  in  1  op is a load.
- ex_mem_write  in  1  op is a store.
- ex_funct3  in  3  RV32I load/store funct3.
- ex_address  in  32  effective address.
- ex_store_data  in  32  rs2 value.
- ex_dest_reg_sel  in  5  load destination register.
- lsu_stall  out  1  combinational; holds upstream.
- dmem_read_ready  out  1  read request.
- dmem_read_address  out  32  word-aligned read address.
- dmem_read_data  in  32  read data.
- dmem_read_valid  in  1  read response.
- dmem_write_ready  out  1  write request.
- dmem_write_address  out  32  word-aligned write address.
- dmem_write_data  out  32  lane-aligned store data.
- dmem_write_byte  out  4  byte enables.
- dmem_write_valid  in  1  write completion.
- wb_valid  out  1  one-cycle load-result pulse.
- wb_dest_reg_sel  out  5  load destination register.
- wb_read_data  out  32  extended load data.
- access_fault  out  1  one-cycle pulse on a misaligned or illegal access.
- fault_address  out  32  faulting address.

Behaviour:
- Reset values: all outputs 0, except dmem_*_address = RESET_ADDR. State is IDLE.
- States: IDLE, RD_WAIT, WR_WAIT.
- Accept condition: state IDLE, ex_valid, !stall, and (ex_mem_read | ex_mem_write). If both read and write are set, the write wins.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned accesses: halfword with addr[0] = 1; word with addr[1:0] != 0.
- On an illegal or misaligned access:
  - No bus request is issued.
  - access_fault pulses one cycle after accept; fault_address = ex_address.
  - State stays IDLE.
- Legal load: IDLE -> RD_WAIT. On the next cycle, dmem_read_ready = 1 with address {addr[31:2], 2'b00}. Request is held until dmem_read_valid.
- Legal store: IDLE -> WR_WAIT. Lane encoding:
  - SB: byte = 1 << addr[1:0], data = byte replicated x4.
  - SH: byte = 0011 or 1100 by addr[1], data = halfword replicated x2.
  - SW: byte = 1111.
- Store completion: on dmem_write_valid in WR_WAIT, drop the request and return to IDLE. No wb_valid is produced.
- Load completion: on dmem_read_valid in RD_WAIT, select the byte/halfword using the registered addr[1:0] and extend it per funct3. wb_valid pulses the following cycle; return to IDLE.
- Minimum latency: 2 cycles from accept to wb_valid.
- lsu_stall = accepting a legal op | (state != IDLE && !response_this_cycle).
- Flush during RD_WAIT: the bus access still completes, but wb_valid is suppressed.
- Flush in IDLE: no effect.
- Asynchronous reset mid-access: immediate return to IDLE; requests drop and any pending response is discarded.
- A response valid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined: an 8-bit+ counter runs in RD_WAIT/WR_WAIT.
  - After TIMEOUT_CYCLES cycles without a response, abort the request.
  - Pulse access_fault with fault_address = request address, and return to IDLE.
- When undefined: no counter; the unit waits indefinitely.

Decomposition:
- Shared package pipe_pkg holds:
  - funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW).
  - State encoding (LSU_IDLE/LSU_RD_WAIT/LSU_WR_WAIT).
  - RESET_ADDR default.
- Sub-module lsu_align: combinational store byte-lane/data generation and load extraction/extension. It is instantiated once and shared by both paths.

Test Plan:
- SB at 0x103, data 0x000000A5, write_valid after 2 cycles -> write_byte = 1000, write_data = 0xA5A5A5A5, address = 0x100, lsu_stall high for 3 cycles.
- LB at 0x102, read_data = 0x0080FF00, read_valid same cycle as request -> wb_read_data = 0xFFFFFF80, wb_valid 2 cycles after accept. LBU at the same address -> 0x00000080.
- LW at 0x1002 -> access_fault pulse, fault_address = 0x1002, no dmem_read_ready, no wb_valid.
- LH at 0x200, flush asserted in RD_WAIT, read_valid with 0x12345678 -> no wb_valid, state returns to IDLE, next op accepted.
- Reset asserted during WR_WAIT -> dmem_write_ready = 0 immediately, addresses = RESET_ADDR; a later stray write_valid is ignored.
- With LSU_TIMEOUT_EN, LW with no response -> access_fault after 255 cycles, request dropped.
